dense_layer_sequencer: RTL

Time-multiplexed controller and datapath for one fully-connected layer. A single shared multiply-accumulate unit replaces one parallel neuron per output. The block latches an input vector and streams weights and biases from an external synchronous weight ROM, one word per cycle. It accumulates each neuron in turn, applies the activation and writes the result to an output register file. It sits between two layers in the network pipeline and uses the same `inputs_ready`/`outputs_ready` handshake as the parallel layers, so the two are interchangeable.

---
 rtl/dense_layer_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: time-multiplexed fully-connected layer.
// One shared multiply-accumulate unit walks every neuron in turn. Weights and
// biases stream from an external synchronous ROM at one word per cycle.
// Optional feature macro: DENSE_SEQ_SATURATE_EN. When it is defined, each
// result clamps to the signed DATA_WIDTH range. When it is undefined, each
// result keeps the low DATA_WIDTH bits (two's-complement wrap).
module dense_layer_sequencer #(
    parameter int    DATA_WIDTH  = 32,
    parameter int    FRAC_BITS   = 16,
    parameter int    NUM_INPUTS  = 16,
    parameter int    NUM_NEURONS = 16,
    parameter string ACTIVATION  = "relu",
    parameter int    ADDR_WIDTH  = $clog2(NUM_NEURONS * (NUM_INPUTS + 1))
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     inputs_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    inputs,
    output logic                                     weight_en,
    output logic [ADDR_WIDTH-1:0]                    weight_addr,
    input  logic [DATA_WIDTH-1:0]                    weight_data,
    output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]   outputs,
    output logic                                     outputs_ready,
    output logic                                     busy
);

    localparam int AW2     = 2 * DATA_WIDTH;
    localparam int NW      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int KW      = $clog2(NUM_INPUTS + 1);
    localparam bit IS_RELU = (ACTIVATION == "relu");

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Activation on the wide bias-added sum.
    function automatic logic signed [AW2-1:0] activate(input logic signed [AW2-1:0] s);
        logic signed [AW2-1:0] r;
        if (IS_RELU && s[AW2-1]) begin
            r = {AW2{1'b0}};
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Narrow the wide result to one output word.
    function automatic logic [DATA_WIDTH-1:0] reduce_word(input logic signed [AW2-1:0] s);
        logic [DATA_WIDTH-1:0] r;
`ifdef DENSE_SEQ_SATURATE_EN
        logic signed [AW2-1:0] sat_max;
        logic signed [AW2-1:0] sat_min;
        sat_max = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
        sat_min = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
        if (s > sat_max) begin
            r = sat_max[DATA_WIDTH-1:0];
        end else if (s < sat_min) begin
            r = sat_min[DATA_WIDTH-1:0];
        end else begin
            r = s[DATA_WIDTH-1:0];
        end
`else
        r = s[DATA_WIDTH-1:0];
`endif
        return r;
    endfunction

    state_t                                   state_q, state_d;
    logic [NW-1:0]                            n_q, n_d;
    logic [KW-1:0]                            k_q, k_d;
    logic                                     en_q, en_d;
    logic [ADDR_WIDTH-1:0]                    addr_q, addr_d;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    x_q, x_d;
    logic                                     cons_valid_q, cons_valid_d;
    logic [NW-1:0]                            cons_n_q, cons_n_d;
    logic [KW-1:0]                            cons_k_q, cons_k_d;
    logic signed [AW2-1:0]                    acc_q, acc_d;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]   out_q, out_d;
    logic                                     ordy_q, ordy_d;
    logic                                     busy_q, busy_d;

    logic [DATA_WIDTH-1:0]                    x_sel_s;
    logic signed [AW2-1:0]                    x_ext_s;
    logic signed [AW2-1:0]                    w_ext_s;
    logic signed [AW2-1:0]                    prod_s;
    logic signed [AW2-1:0]                    sum_s;
    logic [DATA_WIDTH-1:0]                    result_s;

    // Sequencer: start on request, issue one ROM address per cycle, drain, then signal done.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        en_d         = 1'b0;
        addr_d       = addr_q;
        x_d          = x_q;
        ordy_d       = 1'b0;
        busy_d       = busy_q;
        cons_valid_d = en_q;
        cons_n_d     = n_q;
        cons_k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (inputs_ready) begin
                    x_d     = inputs;
                    n_d     = {NW{1'b0}};
                    k_d     = {KW{1'b0}};
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (k_q == KW'(NUM_INPUTS)) begin
                    if (n_q == NW'(NUM_NEURONS - 1)) begin
                        en_d    = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d    = {KW{1'b0}};
                        n_d    = n_q + NW'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        en_d   = 1'b1;
                    end
                end else begin
                    k_d    = k_q + KW'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    en_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                ordy_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Consume stage: multiply-accumulate a weight, or finish a neuron with its bias.
    always_comb begin
        acc_d   = acc_q;
        out_d   = out_q;
        x_sel_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            x_sel_s = (cons_k_q == KW'(i)) ? x_q[i] : x_sel_s;
        end
        x_ext_s  = {{DATA_WIDTH{x_sel_s[DATA_WIDTH-1]}}, x_sel_s};
        w_ext_s  = {{DATA_WIDTH{weight_data[DATA_WIDTH-1]}}, weight_data};
        prod_s   = x_ext_s * w_ext_s;
        sum_s    = activate(acc_q + w_ext_s);
        result_s = reduce_word(sum_s);
        if (cons_valid_q) begin
            if (cons_k_q != KW'(NUM_INPUTS)) begin
                acc_d = acc_q + (prod_s >>> FRAC_BITS);
            end else begin
                acc_d = {AW2{1'b0}};
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    out_d[i] = (cons_n_q == NW'(i)) ? result_s : out_q[i];
                end
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Sequencer and address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= {NW{1'b0}};
            k_q     <= {KW{1'b0}};
            en_q    <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            x_q     <= {(NUM_INPUTS * DATA_WIDTH){1'b0}};
            ordy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            ordy_q  <= ordy_d;
            busy_q  <= busy_d;
        end
    end

    // Consume-stage tags, accumulator and result register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cons_valid_q <= 1'b0;
            cons_n_q     <= {NW{1'b0}};
            cons_k_q     <= {KW{1'b0}};
            acc_q        <= {AW2{1'b0}};
            out_q        <= {(NUM_NEURONS * DATA_WIDTH){1'b0}};
        end else begin
            cons_valid_q <= cons_valid_d;
            cons_n_q     <= cons_n_d;
            cons_k_q     <= cons_k_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
        end
    end

    assign weight_en     = en_q;
    assign weight_addr   = addr_q;
    assign outputs       = out_q;
    assign outputs_ready = ordy_q;
    assign busy          = busy_q;

endmodule
